rr_dispatcher: RTL
==================

Name: rr_dispatcher

Overview:
Round-robin dispatcher: one valid/ready input stream is distributed to 3 consumer channels in rotating order. This is the fan-out counterpart of the 3-way round-robin arbiter, which fans in.
Each channel has a one-entry output holding register. The rotation skips channels whose slot is occupied, so the block is work-conserving and fair.
It sits between a single producer and three parallel engines. Per-channel dispatch counters are provided for debug and load-balance checks.

Parameters:
DW, 8, data width of the input word and of each channel word

Ports:
clk  input  1  clock
asrst  input  1  reset, asynchronous, active-high
en  input  1  dispatch enable; when 0, no new input is accepted
in_vld  input  1  input word valid
in_data  input  DW  input word
in_rdy  output  1  input ready (combinational)
out_vld  output  3  per-channel valid; bit i = channel i
out_data  output  3*DW  channel i word at bits [i*DW +: DW]
out_rdy  input  3  per-channel consumer ready
cur_ptr  output  3  one-hot rotation pointer: the channel with highest priority for the next word
disp_cnt  output  24  channel i count at bits [i*8 +: 8]; words dispatched to channel i, wraps modulo 256

Behaviour:
- Reset values while asrst is high:
  - out_vld = 000, out_data = 0.
  - cur_ptr = 001, disp_cnt = 0.
  - in_rdy forced 0.
- Slot state:
  - free[i] = !out_vld[i] | out_rdy[i].
  - A slot being drained this cycle may be refilled in the same cycle.
- Selection (combinational):
  - Search order starts at cur_ptr and wraps cyclically: ptr, ptr+1, ptr+2, with 2 -> 0.
  - sel = one-hot of the first channel with free[i] = 1.
  - sel = 000 if no channel is free.
- in_rdy = en & !asrst & (|free).
- Accept condition: accept = in_vld & in_rdy. On the clock edge after an accept:
  - slot sel loads in_data and sets out_vld[sel] = 1;
  - cur_ptr becomes the channel after sel (rotate-left of sel, 100 -> 001);
  - disp_cnt[sel] increments, 8-bit wrap 255 -> 0.
- Drain: out_vld[i] & out_rdy[i] with no refill of slot i clears out_vld[i] on the next edge.
- Drain and refill in the same cycle: out_vld[i] stays 1 and out_data[i] takes the new word.
- Stability: while out_vld[i] & !out_rdy[i], out_data[i] must not change. A consumer may assert out_rdy at any time.
- Latency: an accepted word appears on out_vld/out_data exactly 1 cycle after acceptance. There is no combinational in_data -> out_data path.
- Throughput: 1 word per cycle while at least one slot is free.
- No accept (in_vld = 0, en = 0, or all slots full): cur_ptr and disp_cnt hold.
- en = 0 affects input only: existing slots still present and drain normally.
- Ordering:
  - Words to the same channel are delivered in input order.
  - There is no ordering guarantee across channels.
- Exactly one slot is loaded per accept; sel is always one-hot or zero.
- Reset mid-operation: asrst asserted at any time immediately clears all slots (pending words are discarded), cur_ptr and counters. There is no synchronous recovery sequence.
- out_rdy on a channel with out_vld = 0 has no effect.

Test Plan:
1. Reset, en=1, out_rdy=111, feed 6 back-to-back words 0x10..0x15 -> in_rdy stays 1; one cycle after each accept:
   - ch0 receives 0x10, 0x13; ch1 receives 0x11, 0x14; ch2 receives 0x12, 0x15;
   - disp_cnt = {2,2,2}; cur_ptr returns to 001.
2. Skip: out_rdy=101 with ch1 holding a word, cur_ptr=010, send 0x55 -> 0x55 goes to ch2; cur_ptr becomes 001; ch1 data is unchanged.
3. Backpressure: out_rdy=000, send 0xA0, 0xA1, 0xA2, 0xA3:
   - the first three are accepted into ch0/ch1/ch2; in_rdy = 0 with 0xA3 pending;
   - raise out_rdy[2] only -> 0xA3 is accepted in that same cycle into ch2 (drain and refill); out_vld[2] stays 1; cur_ptr = 001.
4. en dropped for 3 cycles mid-stream with out_rdy=111 -> in_rdy = 0; cur_ptr and disp_cnt hold; occupied slots drain to out_vld = 000; dispatch resumes at the held cur_ptr.
5. asrst pulsed while all slots are full and in_vld = 1 -> out_vld = 000, cur_ptr = 001, disp_cnt = 0 on the same cycle; after release, the first word goes to ch0.
6. 768 back-to-back words with out_rdy=111 -> each disp_cnt field wraps to 0x00; no word is lost or duplicated (scoreboard each channel in order).

Source files
------------

// File: rtl/rr_dispatcher_if.sv
// rtl/rr_dispatcher_if.sv - handshake bundle between one producer, the dispatcher and three consumers
//
// Ports carried:
//   in_vld, in_data, in_rdy : producer -> dispatcher valid/ready word stream
//   out_vld[2:0]            : per-channel word present
//   out_data[3*DW-1:0]      : channel i word at [i*DW +: DW]
//   out_rdy[2:0]            : per-channel consumer ready
// Modports:
//   slave  : the dispatcher side
//   master : the environment side (producer plus consumers)
interface rr_dispatcher_if #(
    parameter int DW = 8
);
    logic            in_vld;
    logic [DW-1:0]   in_data;
    logic            in_rdy;
    logic [2:0]      out_vld;
    logic [3*DW-1:0] out_data;
    logic [2:0]      out_rdy;

    modport slave (
        input  in_vld,
        input  in_data,
        input  out_rdy,
        output in_rdy,
        output out_vld,
        output out_data
    );

    modport master (
        output in_vld,
        output in_data,
        output out_rdy,
        input  in_rdy,
        input  out_vld,
        input  out_data
    );
endinterface

// File: rtl/rr_dispatcher.sv
// rtl/rr_dispatcher.sv - 3-way round-robin dispatcher with one-entry holding slot per channel
//
// Ports:
//   clk      : clock
//   asrst    : asynchronous active-high reset; clears slots, pointer and counters at once
//   en       : dispatch enable; gates acceptance only, slots keep draining
//   bus      : rr_dispatcher_if.slave (input stream and three output channels)
//   cur_ptr  : one-hot channel with highest priority for the next word
//   disp_cnt : 8-bit wrapping dispatch count of channel i at [i*8 +: 8]
module rr_dispatcher #(
    parameter int DW = 8
) (
    input  logic           clk,
    input  logic           asrst,
    input  logic           en,
    rr_dispatcher_if.slave bus,
    output logic [2:0]     cur_ptr,
    output logic [23:0]    disp_cnt
);

    logic [2:0]      vld_q, vld_d;
    logic [3*DW-1:0] data_q, data_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [23:0]     cnt_q, cnt_d;

    logic [2:0] free;
    logic [2:0] sel;
    logic       accept;
    logic [1:0] idx0, idx1, idx2;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // A slot is free when empty or when its consumer takes the word this
    // cycle, so a draining slot can be refilled without a bubble.
    always_comb begin
        free = ~vld_q | bus.out_rdy;
    end

    // Search order: cur_ptr, then the next two channels cyclically.
    always_comb begin
        case (ptr_q)
            3'b010:  idx0 = 2'd1;
            3'b100:  idx0 = 2'd2;
            default: idx0 = 2'd0;
        endcase
        idx1 = next_idx(idx0);
        idx2 = next_idx(idx1);
        sel  = 3'b000;
        if (free[idx0]) begin
            sel[idx0] = 1'b1;
        end else if (free[idx1]) begin
            sel[idx1] = 1'b1;
        end else if (free[idx2]) begin
            sel[idx2] = 1'b1;
        end
    end

    assign bus.in_rdy = en & ~asrst & (|free);
    assign accept     = bus.in_vld & bus.in_rdy;

    always_comb begin
        vld_d  = vld_q & ~bus.out_rdy;
        data_d = data_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (accept) begin
            vld_d = vld_d | sel;
            // Pointer moves to the channel after the one just served, which
            // gives fairness even when the rotation skipped busy channels.
            ptr_d = {sel[1:0], sel[2]};
            for (int i = 0; i < 3; i++) begin
                if (sel[i]) begin
                    data_d[i*DW +: DW] = bus.in_data;
                    cnt_d[i*8 +: 8]    = cnt_q[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge asrst) begin
        if (asrst) begin
            vld_q  <= 3'b000;
            data_q <= '0;
            ptr_q  <= 3'b001;
            cnt_q  <= 24'd0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.out_vld  = vld_q;
    assign bus.out_data = data_q;
    assign cur_ptr      = ptr_q;
    assign disp_cnt     = cnt_q;

endmodule
